// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_digits(input int width, input int digit);
    return width / digit;
  endfunction

  localparam int N_DEFAULT = n_digits(32, 4);
  localparam int CNT_W     = (N_DEFAULT > 1) ? $clog2(N_DEFAULT) : 1;

endpackage

// File: rtl/serial_subtractor32_sub_digit.sv
// Combinational DIGIT-bit subtract with borrow; optional SERIAL_SUB_OVF_EN adds
// the borrow into the top bit so the caller can form signed overflow.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             bmsb
`endif
);

  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    diff = full[DIGIT-1:0];
    bout = full[DIGIT];
  end

`ifdef SERIAL_SUB_OVF_EN
  // The borrow into the top bit is the borrow out of the lower DIGIT-1 bits.
  generate
    if (DIGIT > 1) begin : g_mid
      logic [DIGIT-1:0] low;
      always_comb begin
        low  = {1'b0, a[DIGIT-2:0]} - {1'b0, b[DIGIT-2:0]} - {{(DIGIT-1){1'b0}}, bin};
        bmsb = low[DIGIT-1];
      end
    end else begin : g_single
      always_comb bmsb = bin;
    end
  endgenerate
`endif

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial unsigned subtractor: diff = a - b - bin over WIDTH/DIGIT cycles.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor32
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = n_digits(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_subtractor32: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  // Handshake: an operand is taken on an edge with in_valid && in_ready; a result
  // is released on an edge with out_valid && out_ready. Both flags are registered.
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       d_slice;
  logic                   d_bout;
  logic [WIDTH+DIGIT-1:0] diff_cat;
  logic [WIDTH-1:0]       diff_next;
  logic                   last;
`ifdef SERIAL_SUB_OVF_EN
  logic                   d_bmsb;
`endif

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (brw),
    .diff (d_slice),
    .bout (d_bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .bmsb (d_bmsb)
`endif
  );

  // New slice enters at the top so the LSB slice ends up at bit 0 after N steps.
  always_comb begin
    diff_cat  = {d_slice, diff_sh};
    diff_next = diff_cat[WIDTH+DIGIT-1:DIGIT];
    last      = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      diff_sh   <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            brw      <= bin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          diff_sh <= diff_next;
          brw     <= d_bout;
          cnt     <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            diff      <= diff_next;
            bout      <= d_bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= d_bmsb ^ d_bout;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed bench for serial_subtractor32 with an expected-result queue.
module tb_serial_subtractor32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        busy;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf;
  logic        ovf_q[$];
`endif

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  serial_subtractor32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: 33-bit subtraction gives the result and the unsigned borrow.
  task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb, input logic ebin);
    logic [32:0] r;
    r = {1'b0, ea} - {1'b0, eb} - {32'd0, ebin};
    exp_q.push_back(r);
`ifdef SERIAL_SUB_OVF_EN
    ovf_q.push_back((ea[31] ^ eb[31]) & (r[31] ^ ea[31]));
`endif
  endtask

  task automatic start_op(input logic [31:0] sa, input logic [31:0] sb, input logic sbin,
                          input bit keep);
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    bin      = sbin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (keep) push_exp(sa, sb, sbin);
    check("accept_in_ready", 64'(in_ready), 64'd0);
    check("accept_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input bit poke);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
      if (poke) check("run_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'd8);
  endtask

  task automatic finish_op(input int hold);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("diff", 64'(diff), 64'(e[31:0]));
    check("bout", 64'(bout), 64'(e[32]));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 64'(ovf), 64'(ovf_q.pop_front()));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_diff", 64'(diff), 64'(e[31:0]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("retained_diff", 64'(diff), 64'(e[31:0]));
  endtask

  task automatic full_op(input logic [31:0] sa, input logic [31:0] sb, input logic sbin,
                         input bit poke, input int hold);
    start_op(sa, sb, sbin, 1'b1);
    wait_done(poke);
    finish_op(hold);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    full_op(32'd5, 32'd3, 1'b0, 1'b0, 0);
    full_op(32'd0, 32'd1, 1'b0, 1'b0, 0);
    full_op(32'h8000_0000, 32'd1, 1'b0, 1'b0, 0);
    full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    full_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 5);
    full_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      full_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2));

    // Abort in the third RUN cycle; the held result must also clear.
    start_op(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_diff", 64'(diff), 64'd0);
    check("abort_bout", 64'(bout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    full_op(32'd10, 32'd4, 1'b0, 1'b0, 0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor32.md
Name: serial_subtractor32

Overview:
Multi-cycle digit-serial unsigned subtractor with borrow. It is the inverse-direction companion of the team's ripple-carry adder. It computes diff = a - b - bin over WIDTH/DIGIT clock cycles, processing one DIGIT-bit slice per cycle, LSB slice first. It sits behind a valid/ready handshake so arithmetic datapaths can share it without a full-width combinational borrow chain.

Parameters:
WIDTH, 32, operand and result width in bits.
DIGIT, 4, bits processed per cycle. Must divide WIDTH exactly; an elaboration error is raised otherwise.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands a, b and bin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  diff and bout are valid.
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
bout  output  1  borrow out; 1 iff a < b + bin, compared as unsigned values.
busy  output  1  high while the state is RUN.

Behaviour:
- Reset (async assert, all state cleared):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - diff = 0, bout = 0, digit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1, capture a, b and bin into shift registers, clear the counter, go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle, subtract the low DIGIT bits of a_sh and b_sh with the current borrow.
  - Shift the result slice into the top of diff_sh, shift a_sh and b_sh right by DIGIT, and register the new borrow.
  - After N = WIDTH/DIGIT cycles, go to DONE.
- DONE:
  - out_valid = 1; diff and bout come directly from registers and stay stable.
  - Hold until out_ready = 1, then go to IDLE on that edge.
  - in_ready stays 0 in DONE; there is no result/input overlap.
- Latency: out_valid rises exactly N edges after the accepting edge (8 for the defaults). Throughput is one operation per N + 2 cycles minimum.
- diff and bout keep their values after leaving DONE until the next result is loaded.
- Input changes while in RUN or DONE have no effect.
- Reset asserted mid-operation aborts the operation immediately and returns every output to its reset value. No result is produced.
- out_ready asserted outside DONE is ignored.
- Width rules:
  - The slice subtract produces a DIGIT-bit difference plus a 1-bit borrow.
  - The borrow chains between slices through one register.
  - The final registered borrow is bout.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow.
  - ovf = borrow into MSB XOR borrow out of MSB.
  - ovf is registered, valid with out_valid, and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum type (IDLE/RUN/DONE);
  - function n_digits(WIDTH, DIGIT);
  - the counter-width localparam, $clog2 of N.
- One natural sub-module, sub_digit: combinational DIGIT-bit subtract with borrow-in and borrow-out. It is instantiated once and reused every cycle.

Test Plan:
- a=5, b=3, bin=0 -> after 8 cycles, out_valid=1, diff=0x00000002, bout=0.
- a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1. With SERIAL_SUB_OVF_EN, ovf=0.
- a=0x80000000, b=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1 (macro defined).
- a=b=0xFFFFFFFF, bin=1 -> diff=0xFFFFFFFF, bout=1. in_ready stays 0 and in_valid pulses are ignored during RUN.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and diff is stable. Then out_ready=1 -> IDLE next edge, in_ready=1.
- Assert rst for 1 cycle at RUN cycle 3 -> all outputs return to reset values immediately. The next operation (a=10, b=4) gives diff=6 with the correct latency.
